// File: rtl/alu_result_mux.sv
// Registered ALU result selector: picks one of NSRC unit results, flags zero/error,
// and buffers it in a 2-entry valid/ready queue ahead of writeback.
module alu_result_mux #(
  parameter int WIDTH = 4,
  parameter int NSRC  = 4,
  parameter int SEL_W = 2,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_zero,
  output logic                  out_err,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERR_W-1:0]      err_count
);

  logic [1:0]       count;
  logic [WIDTH-1:0] next_data;
  logic             next_zero;
  logic             next_err;
  logic [SEL_W-1:0] next_sel;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             push;
  logic             pop;

  // Selects outside 0..NSRC-1 match no source, so they fall through as data 0 with err set.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        cap_data = src_data[i*WIDTH +: WIDTH];
        cap_err  = !src_valid[i];
      end
    end
  end

  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head entry lives directly in the out_* registers; the second slot only fills when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
      out_sel   <= '0;
      next_data <= '0;
      next_zero <= 1'b0;
      next_err  <= 1'b0;
      next_sel  <= '0;
      err_count <= '0;
    end else begin
      if (push && cap_err && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);

      if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
        out_data <= cap_data;
        out_zero <= (cap_data == '0);
        out_err  <= cap_err;
        out_sel  <= sel;
      end else if (push) begin
        next_data <= cap_data;
        next_zero <= (cap_data == '0);
        next_err  <= cap_err;
        next_sel  <= sel;
      end else if (pop && (count == 2'd2)) begin
        out_data <= next_data;
        out_zero <= next_zero;
        out_err  <= next_err;
        out_sel  <= next_sel;
      end

      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_mux.sv
// Directed bench for alu_result_mux: one 4-source instance and one 3-source instance
// for the illegal-select and counter-saturation cases.
module tb_alu_result_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] src_data;
  logic [3:0]  src_valid;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_data;
  logic        out_zero;
  logic        out_err;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  logic [11:0] src_data3;
  logic [2:0]  src_valid3;
  logic [1:0]  sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [3:0]  out_data3;
  logic        out_zero3;
  logic        out_err3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;
  logic [7:0]  err_count3;

  int errors = 0;
  int checks = 0;

  alu_result_mux #(.WIDTH(4), .NSRC(4), .SEL_W(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_zero(out_zero),
    .out_err(out_err), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count)
  );

  alu_result_mux #(.WIDTH(4), .NSRC(3), .SEL_W(2), .ERR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .src_data(src_data3), .src_valid(src_valid3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_zero(out_zero3),
    .out_err(out_err3), .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_count(err_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one request, then advances one clock so outputs can be sampled 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s);
    in_valid = v;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] stream_exp [4];

  initial begin
    stream_exp[0] = 4'h3; stream_exp[1] = 4'h5; stream_exp[2] = 4'hC; stream_exp[3] = 4'h9;
    rst_n = 1'b0; src_data = 16'h9C53; src_valid = 4'hF; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
    src_data3 = 12'h9C5; src_valid3 = 3'b111; sel3 = 2'd0; in_valid3 = 1'b0; out_ready3 = 1'b1;

    applyStimulus(1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic select, one result per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i));
      checkOutput("basic_valid", 32'(out_valid), 32'd1);
      checkOutput("basic_data", 32'(out_data), 32'(stream_exp[i]));
      checkOutput("basic_sel", 32'(out_sel), 32'(i));
    end
    applyStimulus(1'b0, 2'd0);
    checkOutput("basic_drained", 32'(out_valid), 32'd0);
    checkOutput("basic_hold_data", 32'(out_data), 32'h9);
    checkOutput("basic_err_count", 32'(err_count), 32'd0);

    // backpressure
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'd1);
    checkOutput("bp_first_data", 32'(out_data), 32'h5);
    checkOutput("bp_ready_after1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 2'd2);
    checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 2'd3);
    checkOutput("bp_stall_data", 32'(out_data), 32'h5);
    checkOutput("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b0, 2'd0);
    checkOutput("bp_second_data", 32'(out_data), 32'hC);
    checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("bp_no_third", 32'(out_valid), 32'd0);

    // error and zero flags
    src_valid = 4'b1011;
    applyStimulus(1'b1, 2'd2);
    checkOutput("err_flag", 32'(out_err), 32'd1);
    checkOutput("err_data", 32'(out_data), 32'hC);
    checkOutput("err_count_1", 32'(err_count), 32'd1);
    src_data = 16'h9C50;
    applyStimulus(1'b1, 2'd0);
    checkOutput("zero_flag", 32'(out_zero), 32'd1);
    checkOutput("zero_err", 32'(out_err), 32'd0);
    checkOutput("zero_data", 32'(out_data), 32'd0);
    checkOutput("err_count_hold", 32'(err_count), 32'd1);
    applyStimulus(1'b0, 2'd0);
    src_data = 16'h9C53;
    src_valid = 4'hF;

    // continuous stream with simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'(i % 4));
      checkOutput("stream_data", 32'(out_data), 32'(stream_exp[i % 4]));
      checkOutput("stream_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(1'b0, 2'd0);
    checkOutput("stream_drained", 32'(out_valid), 32'd0);

    // reset mid-stream with a full queue
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd1);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 2'd0);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_errcnt", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 2'd0);
    checkOutput("mid_no_stale", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 2'd3);
    checkOutput("mid_new_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_new_data", 32'(out_data), 32'h9);
    applyStimulus(1'b0, 2'd0);
    checkOutput("mid_no_old", 32'(out_valid), 32'd0);

    // illegal select on the 3-source instance, then saturation
    in_valid3 = 1'b1;
    sel3 = 2'd3;
    @(posedge clk);
    #1;
    checkOutput("ill_data", 32'(out_data3), 32'd0);
    checkOutput("ill_zero", 32'(out_zero3), 32'd1);
    checkOutput("ill_err", 32'(out_err3), 32'd1);
    checkOutput("ill_sel", 32'(out_sel3), 32'd3);
    checkOutput("ill_count1", 32'(err_count3), 32'd1);
    for (int i = 0; i < 299; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("sat_count", 32'(err_count3), 32'd255);
    sel3 = 2'd2;
    @(posedge clk);
    #1;
    checkOutput("legal3_data", 32'(out_data3), 32'h9);
    checkOutput("legal3_err", 32'(out_err3), 32'd0);
    checkOutput("sat_hold", 32'(err_count3), 32'd255);
    in_valid3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
